tpu_tile_controller: RTL
========================

# tpu_tile_controller

Parametrised sequencing FSM for the N×N INT8 weight-stationary systolic array, supporting multi-tile K-dimension accumulation. One `start` runs: one accumulator clear, then per tile an N-cycle row-wise weight load and a 2N-cycle compute phase, then an output handshake and a `done` pulse. Also adds abort, configuration error detection and a ready/valid result handshake. Sits between the host command interface and the array, weight buffer and accumulator bank.

## Interface

- N, default 8: array dimension; must be ≥ 2.
- MAX_TILES, default 16: maximum tiles per job; must be ≥ 1.
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: job request; sampled only in IDLE.
- cfg_num_tiles  in  $clog2(MAX_TILES+1): tile count for the job; latched on accepted `start`.
- abort  in  1: cancels the running job.
- out_ready  in  1: downstream accepts the result.
- busy  out  1: high in every state except IDLE.
- clear_acc  out  1: high in CLEAR.
- load_weight  out  1: high in LOAD.
- load_row  out  $clog2(N): row index during LOAD; 0 otherwise.
- compute_en  out  1: high in COMPUTE.
- compute_cycle  out  $clog2(2N): cycle index within COMPUTE; 0 otherwise.
- tile_idx  out  $clog2(MAX_TILES+1): current tile, 0-based; 0 in IDLE.
- output_valid  out  1: high in OUTPUT.
- done  out  1: one-cycle pulse in DONE.
- aborted  out  1: one-cycle pulse after an abort.
- cfg_err  out  1: one-cycle pulse on a rejected `start`.

## Operation

- States: IDLE, CLEAR, LOAD, COMPUTE, OUTPUT, DONE.
- Registers:
  - `state`
  - phase counter `cnt`, width $clog2(2N)
  - `tile_idx`
  - latched `num_tiles`
  - `aborted` and `cfg_err` pulse flops
- Outputs are decoded from registered state and counters. There are no combinational input-to-output paths.
- IDLE:
  - `start` with 1 ≤ cfg_num_tiles ≤ MAX_TILES: latch `num_tiles`, clear `tile_idx`, go to CLEAR.
  - `start` with cfg_num_tiles == 0 or > MAX_TILES: `cfg_err` pulses on the next cycle; stay in IDLE.
- CLEAR: lasts 1 cycle; `cnt` ← 0; go to LOAD. The accumulator is cleared once per job, not per tile.
- LOAD:
  - `load_row` = `cnt`.
  - At `cnt` == N-1: `cnt` ← 0 and go to COMPUTE. Otherwise `cnt` increments.
- COMPUTE:
  - `compute_cycle` = `cnt`.
  - At `cnt` == 2N-1: `cnt` ← 0.
    - If `tile_idx` == num_tiles-1, go to OUTPUT.
    - Otherwise `tile_idx` increments and go to LOAD.
- OUTPUT: hold `output_valid` until `out_ready` is high, then go to DONE. The handshake completes in the cycle where both are high.
- DONE: `done` high for exactly 1 cycle; go to IDLE.
- `abort` in any state other than IDLE, including OUTPUT and DONE:
  - Next state is IDLE; counters are cleared.
  - `aborted` pulses for 1 cycle.
  - `done` and `output_valid` are not asserted.
  - `abort` takes priority over every other transition in the same cycle. `abort` in IDLE is ignored.
- `start` outside IDLE is ignored. It is not queued.
- `start` asserted in the DONE cycle is ignored. A new job needs `start` in IDLE.

## Timing

- Reset (rst_n low, asynchronous):
  - `state` = IDLE.
  - All outputs, `cnt`, `tile_idx` and `num_tiles` are 0.
  - Deasserting reset mid-job leaves the block in IDLE with no pulse on any output.
- Cycle numbering: cycle 0 is the edge where `start` is sampled in IDLE. Then:
  - CLEAR at cycle 1.
  - Tile t has LOAD at cycles 2+3N·t … 1+3N·t+N.
  - COMPUTE follows immediately for 2N cycles.
  - OUTPUT first appears at cycle 2+3N·T.
- With `out_ready` held high: one OUTPUT cycle, DONE at 3+3N·T, IDLE at 4+3N·T.
- Every OUTPUT cycle with `out_ready` low adds exactly 1 cycle.
- There is no idle gap between tiles: the last COMPUTE cycle of tile t is followed directly by LOAD row 0 of tile t+1.
- `busy` is high from cycle 1 through the DONE cycle inclusive.

## Test plan

- **Single tile, back-to-back handshake.** N=4, cfg_num_tiles=1, out_ready=1, start at cycle 0.
  - `clear_acc` at cycle 1.
  - `load_weight` at cycles 2–5 with `load_row` 0,1,2,3.
  - `compute_en` at cycles 6–13 with `compute_cycle` 0–7.
  - `output_valid` at cycle 14, `done` at cycle 15, IDLE at 16.
- **Multi-tile.** N=4, cfg_num_tiles=3.
  - Exactly one `clear_acc`.
  - `tile_idx` = 0 at cycles 2–13, 1 at 14–25, 2 at 26–37.
  - `output_valid` at cycle 38.
- **Output backpressure.** N=4, T=1, out_ready low until cycle 20.
  - `output_valid` held at cycles 14–20.
  - `done` at cycle 21; `done` never high before the handshake.
- **Abort.** Abort at cycle 8 (COMPUTE).
  - `aborted` pulses at cycle 9; IDLE at cycle 9.
  - No `done` and no `output_valid`.
  - A new `start` at cycle 10 runs normally.
  - Repeat with abort during OUTPUT: no `done`.
- **Configuration error.** `start` with cfg_num_tiles=0, then with MAX_TILES+1.
  - `cfg_err` pulses 1 cycle after each; `busy` stays 0.
  - `start` with MAX_TILES completes normally.
- **Reset and ignored start.** Assert rst_n low asynchronously mid-LOAD.
  - All outputs read 0 immediately.
  - After release: IDLE, no pulses.
  - `start` pulsed during COMPUTE is ignored: a single `done` only.

Source files
------------

// File: rtl/tpu_tile_controller_if.sv
// tpu_tile_controller_if
//   Bundles the controller's host command and array sequencing signals.
//   master: host/array side (drives start, cfg_num_tiles, abort, out_ready)
//   slave : controller side (drives status, pulses and array strobes)
interface tpu_tile_controller_if #(
  parameter int N         = 8,
  parameter int MAX_TILES = 16
);
  localparam int TW = $clog2(MAX_TILES + 1);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(2 * N);

  logic          start;
  logic [TW-1:0] cfg_num_tiles;
  logic          abort;
  logic          out_ready;
  logic          busy;
  logic          clear_acc;
  logic          load_weight;
  logic [RW-1:0] load_row;
  logic          compute_en;
  logic [CW-1:0] compute_cycle;
  logic [TW-1:0] tile_idx;
  logic          output_valid;
  logic          done;
  logic          aborted;
  logic          cfg_err;

  modport master (
    output start, cfg_num_tiles, abort, out_ready,
    input  busy, clear_acc, load_weight, load_row, compute_en, compute_cycle,
           tile_idx, output_valid, done, aborted, cfg_err
  );

  modport slave (
    input  start, cfg_num_tiles, abort, out_ready,
    output busy, clear_acc, load_weight, load_row, compute_en, compute_cycle,
           tile_idx, output_valid, done, aborted, cfg_err
  );
endinterface

// File: rtl/tpu_tile_controller.sv
// tpu_tile_controller
//   Sequences one job on the NxN weight-stationary array: a single
//   accumulator clear, then per tile an N-cycle weight load and a 2N-cycle
//   compute, then a ready/valid result handshake and a done pulse.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    tpu_tile_controller_if.slave (command, status, array strobes)
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for start; cfg_num_tiles checked here
//   CLEAR   | one-cycle accumulator clear for the whole job
//   LOAD    | weight row cnt loaded into the array
//   COMPUTE | compute cycle cnt of the current tile
//   OUTPUT  | result offered, waiting for out_ready
//   DONE    | one-cycle completion pulse
module tpu_tile_controller #(
  parameter int N         = 8,
  parameter int MAX_TILES = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  tpu_tile_controller_if.slave bus
);
  localparam int TW = $clog2(MAX_TILES + 1);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(2 * N);

  localparam logic [CW-1:0] LOAD_LAST = CW'(N - 1);
  localparam logic [CW-1:0] COMP_LAST = CW'(2 * N - 1);
  localparam logic [TW-1:0] TILE_MAX  = TW'(MAX_TILES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tile_idx;
  logic [TW-1:0] num_tiles;
  logic          aborted;
  logic          cfg_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tile_idx  <= '0;
      num_tiles <= '0;
      aborted   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      aborted <= 1'b0;
      cfg_err <= 1'b0;
      // abort beats every other transition, but means nothing while idle
      if (bus.abort && state != S_IDLE) begin
        state    <= S_IDLE;
        cnt      <= '0;
        tile_idx <= '0;
        aborted  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.cfg_num_tiles != '0 && bus.cfg_num_tiles <= TILE_MAX) begin
                num_tiles <= bus.cfg_num_tiles;
                tile_idx  <= '0;
                cnt       <= '0;
                state     <= S_CLEAR;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            cnt   <= '0;
            state <= S_LOAD;
          end
          S_LOAD: begin
            if (cnt == LOAD_LAST) begin
              cnt   <= '0;
              state <= S_COMPUTE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_COMPUTE: begin
            if (cnt == COMP_LAST) begin
              cnt <= '0;
              if (tile_idx == num_tiles - TW'(1)) begin
                state <= S_OUTPUT;
              end else begin
                // next tile starts loading with no gap; accumulator keeps its sum
                tile_idx <= tile_idx + TW'(1);
                state    <= S_LOAD;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_OUTPUT: begin
            if (bus.out_ready) begin
              state <= S_DONE;
            end
          end
          S_DONE: begin
            tile_idx <= '0;
            state    <= S_IDLE;
          end
          default: begin
            state    <= S_IDLE;
            cnt      <= '0;
            tile_idx <= '0;
          end
        endcase
      end
    end
  end

  assign bus.busy          = (state != S_IDLE);
  assign bus.clear_acc     = (state == S_CLEAR);
  assign bus.load_weight   = (state == S_LOAD);
  assign bus.load_row      = (state == S_LOAD) ? cnt[RW-1:0] : '0;
  assign bus.compute_en    = (state == S_COMPUTE);
  assign bus.compute_cycle = (state == S_COMPUTE) ? cnt : '0;
  assign bus.tile_idx      = tile_idx;
  assign bus.output_valid  = (state == S_OUTPUT);
  assign bus.done          = (state == S_DONE);
  assign bus.aborted       = aborted;
  assign bus.cfg_err       = cfg_err;
endmodule
